// File: rtl/updn_counter_mod.sv
// Parametrised synchronous up/down counter with modulus, clear, load,
// wrap/saturate mode, cascadable terminal count and sticky overflow.
module updn_counter_mod #(
    parameter int unsigned     WIDTH  = 4,
    parameter longint unsigned MAXVAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             updown,
    input  logic             sclr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAXVAL);

    logic             at_max;
    logic             at_zero;
    logic             at_limit;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    // Limit detection for the currently requested direction
    always_comb begin
        at_max   = (q == MAX_Q);
        at_zero  = (q == '0);
        at_limit = updown ? at_zero : at_max;
    end

    // Terminal count is left combinational so a downstream stage can
    // advance on the same edge as this one.
    assign tc = en & at_limit;

    // Next-state: sclr > ld > en > hold
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        ovf_nxt  = ovf;
        if (sclr) begin
            q_nxt   = '0;
            ovf_nxt = 1'b0;
        end else if (ld) begin
            q_nxt = (d > MAX_Q) ? MAX_Q : d;
        end else if (en) begin
            if (at_limit) begin
                ovf_nxt = 1'b1;
                if (!sat) begin
                    q_nxt    = updown ? MAX_Q : '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                q_nxt = updown ? (q - WIDTH'(1)) : (q + WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_updn_counter_mod.sv
// Scoreboard bench for updn_counter_mod: directed vectors on a decade counter
// plus a two-digit cascade.
module tb_updn_counter_mod;

    logic       clk;
    logic       nrst;
    logic       en, updown, sclr, ld, sat;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap, ovf;

    logic       cen;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wrap_lo, wrap_hi, ovf_lo, ovf_hi;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int         kind;
        logic [3:0] a;
        logic [3:0] b;
        logic       w;
        logic       w2;
        logic       o;
        logic       t;
        logic       t2;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t r;

    updn_counter_mod #(.WIDTH(4), .MAXVAL(9)) dut (
        .clk(clk), .nrst(nrst), .en(en), .updown(updown), .sclr(sclr),
        .ld(ld), .d(d), .sat(sat), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    updn_counter_mod #(.WIDTH(4), .MAXVAL(9)) u_lo (
        .clk(clk), .nrst(nrst), .en(cen), .updown(1'b0), .sclr(1'b0),
        .ld(1'b0), .d(4'd0), .sat(1'b0), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .ovf(ovf_lo)
    );

    updn_counter_mod #(.WIDTH(4), .MAXVAL(9)) u_hi (
        .clk(clk), .nrst(nrst), .en(tc_lo), .updown(1'b0), .sclr(1'b0),
        .ld(1'b0), .d(4'd0), .sat(1'b0), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .ovf(ovf_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge the design presents a new state; pop and compare
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            n_checks++;
            if (r.kind == 0) begin
                if ({q, wrap, ovf, tc} !== {r.a, r.w, r.o, r.t}) begin
                    n_fails++;
                    $display("FAIL %s: got q=%0d wrap=%0b ovf=%0b tc=%0b, want q=%0d wrap=%0b ovf=%0b tc=%0b",
                             r.name, q, wrap, ovf, tc, r.a, r.w, r.o, r.t);
                end
            end else begin
                if ({q_hi, q_lo, wrap_hi, wrap_lo, tc_hi, tc_lo} !==
                    {r.b, r.a, r.w2, r.w, r.t2, r.t}) begin
                    n_fails++;
                    $display("FAIL %s: got hi:lo=%0d:%0d wrap h/l=%0b/%0b tc h/l=%0b/%0b, want %0d:%0d %0b/%0b %0b/%0b",
                             r.name, q_hi, q_lo, wrap_hi, wrap_lo, tc_hi, tc_lo,
                             r.b, r.a, r.w2, r.w, r.t2, r.t);
                end
            end
        end
    end

    // Drive one edge's inputs at a falling edge and queue the state expected after it
    task automatic step(input logic e, input logic u, input logic c, input logic l,
                        input logic s, input logic [3:0] dv,
                        input logic [3:0] eq, input logic ew, input logic eo,
                        input string nm);
        exp_t x;
        en = e; updown = u; sclr = c; ld = l; sat = s; d = dv;
        x.kind = 0; x.a = eq; x.b = 4'd0; x.w = ew; x.w2 = 1'b0; x.o = eo;
        x.t = e & (u ? (eq == 4'd0) : (eq == 4'd9)); x.t2 = 1'b0; x.name = nm;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic check_now(input string nm, input logic [5:0] act, input logic [5:0] want);
        n_checks++;
        if (act !== want) begin
            n_fails++;
            $display("FAIL %s: got {q,wrap,ovf}=%b, want %b", nm, act, want);
        end
    endtask

    initial begin
        logic [3:0] seq1 [12];
        exp_t       cx;
        int         lo, hi;

        seq1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        nrst = 1'b0; cen = 1'b0;
        en = 1'b0; updown = 1'b0; sclr = 1'b0; ld = 1'b0; sat = 1'b0; d = 4'd0;

        #2;
        check_now("reset_async", {q, wrap, ovf}, 6'b0000_0_0);
        @(negedge clk);
        nrst = 1'b1;

        // Decade count up from reset, wrapping after 9
        for (int i = 0; i < 12; i++)
            step(1, 0, 0, 0, 0, 4'd0, seq1[i], seq1[i] == 4'd0, i >= 9, "up_decade");

        // sclr wins over en; tc high at q==0 counting down, then wrap to 9
        step(1, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, "sclr_prio");
        step(1, 1, 0, 0, 0, 4'd0, 4'd9, 1, 1, "down_wrap");
        step(1, 1, 0, 0, 0, 4'd0, 4'd8, 0, 1, "down_8");
        step(1, 1, 0, 0, 0, 4'd0, 4'd7, 0, 1, "down_7");

        // Saturating mode
        step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, "sclr");
        step(0, 0, 0, 1, 1, 4'd8, 4'd8, 0, 0, "ld_8");
        step(1, 0, 0, 0, 1, 4'd0, 4'd9, 0, 0, "sat_up1");
        step(1, 0, 0, 0, 1, 4'd0, 4'd9, 0, 1, "sat_up2");
        step(1, 0, 0, 0, 1, 4'd0, 4'd9, 0, 1, "sat_up3");
        step(1, 1, 0, 0, 1, 4'd0, 4'd8, 0, 1, "sat_down");

        // Load clamp, sclr over ld, saturate at zero, hold, load keeps ovf
        step(1, 0, 0, 1, 0, 4'd15, 4'd9, 0, 1, "ld_clamp");
        step(1, 0, 1, 1, 0, 4'd5,  4'd0, 0, 0, "ld_sclr");
        step(1, 1, 0, 0, 1, 4'd0,  4'd0, 0, 1, "sat_down_zero");
        step(0, 1, 0, 0, 1, 4'd0,  4'd0, 0, 1, "hold");
        step(1, 0, 0, 1, 0, 4'd3,  4'd3, 0, 1, "ld_over_en");

        // Count to 7 with ovf set, then reset asynchronously between edges
        step(0, 0, 0, 1, 0, 4'd9, 4'd9, 0, 1, "ld_9");
        step(1, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, "up_wrap2");
        step(0, 0, 0, 1, 0, 4'd6, 4'd6, 0, 1, "ld_6");
        step(1, 0, 0, 0, 0, 4'd0, 4'd7, 0, 1, "up_7");
        #2;
        nrst = 1'b0;
        #1;
        check_now("reset_mid_count", {q, wrap, ovf}, 6'b0000_0_0);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "reset_held");
        nrst = 1'b1;
        step(1, 0, 0, 0, 0, 4'd0, 4'd1, 0, 0, "resume_1");
        step(1, 0, 0, 0, 0, 4'd0, 4'd2, 0, 0, "resume_2");
        step(0, 0, 0, 0, 0, 4'd0, 4'd2, 0, 0, "idle");

        // Two-digit cascade, both stages held at 00 since the last reset
        cen = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            lo = n % 10;
            hi = (n / 10) % 10;
            cx.kind = 1;
            cx.a  = 4'(lo);
            cx.b  = 4'(hi);
            cx.w  = (lo == 0);
            cx.w2 = (n == 100);
            cx.o  = 1'b0;
            cx.t  = (lo == 9);
            cx.t2 = (lo == 9) && (hi == 9);
            cx.name = "cascade";
            sb.push_back(cx);
            @(negedge clk);
        end
        cen = 1'b0;

        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
